// File: rtl/sim_video_pattern_gen_pkg.sv
// rtl/sim_video_pattern_gen_pkg.sv - shared types and bar colour table for the video pattern source
package sim_video_pkg;

  typedef enum logic [1:0] {
    MODE_COUNTER = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_RAMP    = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_LGAP,
    S_FGAP,
    S_DONE
  } state_e;

  // Bar colours as {R,G,B} on/off masks; each set bit widens to an all-ones component.
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/sim_video_pattern_gen_if.sv
// rtl/sim_video_pattern_gen_if.sv - video stream bundle between the pattern source and its sink
interface sim_video_pattern_gen_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  vtvalid;
  logic [DATA_WIDTH-1:0] vtdata;
  logic                  vtlast;
  logic                  vtuser;
  logic                  vtready;

  modport master (output vtvalid, output vtdata, output vtlast, output vtuser, input vtready);
  modport slave  (input vtvalid, input vtdata, input vtlast, input vtuser, output vtready);
endinterface

// File: rtl/sim_video_pattern_gen_pattern.sv
// rtl/sim_video_pattern_gen_pattern.sv - combinational pixel generator for all test patterns
module sim_video_pattern
  import sim_video_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int COMP_WIDTH = 8,
  parameter int H_ACTIVE   = 640,
  parameter int CHECK_LOG2 = 3,
  parameter int XW         = 10,
  parameter int YW         = 9
) (
  input  mode_e                 mode,
  input  logic [XW-1:0]         x,
  input  logic [YW-1:0]         y,
  output logic [DATA_WIDTH-1:0] pixel
);

  logic [2:0] bar_idx;
  logic [2:0] mask;
  logic       chk_on;

  assign bar_idx = 3'((32'(x) << 3) / 32'(H_ACTIVE));
  assign mask    = bar_mask(bar_idx);
  assign chk_on  = 1'((32'(x) ^ 32'(y)) >> CHECK_LOG2);

  always_comb begin
    pixel = '0;
    case (mode)
      MODE_COUNTER: pixel = DATA_WIDTH'(y) * DATA_WIDTH'(H_ACTIVE) + DATA_WIDTH'(x);
      MODE_BARS:    pixel = DATA_WIDTH'({{COMP_WIDTH{mask[2]}}, {COMP_WIDTH{mask[1]}},
                                         {COMP_WIDTH{mask[0]}}});
      MODE_RAMP:    pixel = DATA_WIDTH'({3{COMP_WIDTH'(x)}});
      MODE_CHECKER: pixel = chk_on ? '1 : '0;
      default:      pixel = '0;
    endcase
  end

endmodule

// File: rtl/sim_video_pattern_gen.sv
// rtl/sim_video_pattern_gen.sv - frame sequencer, counters and registered stream outputs
module sim_video_pattern_gen
  import sim_video_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int COMP_WIDTH  = 8,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LINE_GAP    = 0,
  parameter int FRAME_GAP   = 0,
  parameter int CHECK_LOG2  = 3,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  sim_video_pattern_gen_if.master vid,
  output logic                   busy,
  output logic                   done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int XW   = $clog2(H_ACTIVE);
  localparam int YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int GMAX = (LINE_GAP > FRAME_GAP) ? ((LINE_GAP > 1) ? LINE_GAP : 1)
                                               : ((FRAME_GAP > 1) ? FRAME_GAP : 1);
  localparam int GW   = $clog2(GMAX + 1);

  localparam logic [XW-1:0] X_LAST    = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(V_ACTIVE - 1);
  localparam logic [GW-1:0] LGAP_LOAD = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
  localparam logic [GW-1:0] FGAP_LOAD = GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

  state_e                 state_q, state_d, dest_q, dest_d, frame_dest, go_state;
  logic                   go;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
  mode_e                  mode_q, mode_d;
  logic                   valid_q, valid_d, done_d;
  logic                   last_q, user_q, busy_q, done_q;
  logic [DATA_WIDTH-1:0]  data_q, pixel;

  sim_video_pattern #(
    .DATA_WIDTH (DATA_WIDTH),
    .COMP_WIDTH (COMP_WIDTH),
    .H_ACTIVE   (H_ACTIVE),
    .CHECK_LOG2 (CHECK_LOG2),
    .XW         (XW),
    .YW         (YW)
  ) u_pattern (
    .mode  (mode_d),
    .x     (x_d),
    .y     (y_d),
    .pixel (pixel)
  );

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    x_d        = x_q;
    y_d        = y_q;
    gap_d      = gap_q;
    fcnt_d     = fcnt_q;
    mode_d     = mode_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    go         = 1'b0;
    go_state   = S_IDLE;
    frame_dest = S_IDLE;

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          mode_d   = mode_e'(mode);
          fcnt_d   = '0;
          x_d      = '0;
          y_d      = '0;
          go       = 1'b1;
          go_state = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (vid.vtready) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q != Y_LAST) begin
              y_d = y_q + YW'(1);
              if (LINE_GAP != 0) begin
                state_d = S_LGAP;
                gap_d   = LGAP_LOAD;
                valid_d = 1'b0;
              end
            end else begin
              y_d    = '0;
              fcnt_d = fcnt_q + FRAME_CNT_W'(1);
              // The run-length/start decision is taken here so a start drop never truncates a frame.
              if (num_frames != '0 && fcnt_d == num_frames) begin
                frame_dest = S_DONE;
              end else if (!start) begin
                frame_dest = S_IDLE;
              end else begin
                frame_dest = S_ACTIVE;
                mode_d     = mode_e'(mode);
              end
              if (FRAME_GAP == 0) begin
                go       = 1'b1;
                go_state = frame_dest;
              end else begin
                state_d = S_FGAP;
                dest_d  = frame_dest;
                gap_d   = FGAP_LOAD;
                valid_d = 1'b0;
              end
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_LGAP: begin
        if (gap_q == '0) begin
          go       = 1'b1;
          go_state = S_ACTIVE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      S_FGAP: begin
        if (gap_q == '0) begin
          go       = 1'b1;
          go_state = dest_q;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (go) begin
      state_d = go_state;
      valid_d = (go_state == S_ACTIVE);
      done_d  = (go_state == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dest_q  <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      gap_q   <= '0;
      fcnt_q  <= '0;
      mode_q  <= MODE_COUNTER;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      x_q     <= x_d;
      y_q     <= y_d;
      gap_q   <= gap_d;
      fcnt_q  <= fcnt_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      data_q  <= valid_d ? pixel : '0;
      last_q  <= valid_d && (x_d == X_LAST);
      user_q  <= valid_d && (x_d == '0) && (y_d == '0);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
    end
  end

  assign vid.vtvalid = valid_q;
  assign vid.vtdata  = data_q;
  assign vid.vtlast  = last_q;
  assign vid.vtuser  = user_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: doc/sim_video_pattern_gen.md
Name: sim_video_pattern_gen

Overview:
Parametrised successor to the simple simulation video source. Generates whole frames of AXI4-Stream video with selectable test patterns.
- Marks start-of-frame on vtuser and end-of-line on vtlast.
- Inserts programmable idle gaps between lines and between frames.
- Honours vtready backpressure.
- Sits at the head of the video pipeline in simulation and on-board bring-up, feeding the rectify datapath.

Parameters:
- DATA_WIDTH, 24: pixel width. Must be 3*COMP_WIDTH.
- COMP_WIDTH, 8: per-component width, packed as {R,G,B} with R in the MSBs.
- H_ACTIVE, 640: pixels per line (>=8).
- V_ACTIVE, 480: lines per frame (>=1).
- LINE_GAP, 0: idle cycles (vtvalid=0) after each line except the last of a frame.
- FRAME_GAP, 0: idle cycles after the last line of a frame.
- CHECK_LOG2, 3: checkerboard square size = 2^CHECK_LOG2 pixels.
- FRAME_CNT_W, 16: width of num_frames and frame_cnt.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- start  in  1  level enable; generation runs while high
- mode  in  2  pattern select: 0 counter, 1 colour bars, 2 ramp, 3 checkerboard
- num_frames  in  FRAME_CNT_W  frames per run; 0 = continuous
- vtvalid  out  1  AXIS tvalid
- vtdata  out  DATA_WIDTH  AXIS tdata (pixel)
- vtlast  out  1  AXIS tlast, end of line
- vtuser  out  1  AXIS tuser, first pixel of frame
- vtready  in  1  AXIS tready
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse when a finite run completes
- frame_cnt  out  FRAME_CNT_W  frames fully transferred in the current run

Behaviour:
- Reset (async assert, sync release): state IDLE; x, y, gap counter and frame_cnt = 0; all outputs 0.
- All outputs are registered. A beat transfers on vtvalid&&vtready.
- States: IDLE, ACTIVE, LGAP, FGAP, DONE.
- IDLE:
  - start=1 -> ACTIVE.
  - Latch mode into mode_q, clear frame_cnt.
  - First vtvalid=1 appears the cycle after start is sampled high; that beat has x=0, y=0, vtuser=1.
- ACTIVE:
  - vtvalid=1.
  - vtdata, vtlast and vtuser are held stable while vtvalid&&!vtready.
  - On each transfer, x increments.
  - vtlast=1 when x=H_ACTIVE-1.
  - vtuser=1 only when x=0 and y=0.
- End of line, transfer with x=H_ACTIVE-1:
  - x=0.
  - If y<V_ACTIVE-1: y++, go to LGAP (skip straight to ACTIVE if LINE_GAP=0).
  - Otherwise: y=0, frame_cnt++, go to FGAP (skip if FRAME_GAP=0).
- LGAP/FGAP:
  - vtvalid=0 for exactly the gap count of cycles.
  - vtready is ignored during gaps.
- Frame boundary decision, made at the last transfer of a frame:
  - num_frames!=0 and frame_cnt+1==num_frames -> DONE, after FGAP.
  - start=0 -> IDLE, after FGAP.
  - Otherwise -> ACTIVE, re-latching mode_q. Mode only changes at frame boundaries.
- start deassert mid-frame: the current frame completes in full; it never truncates.
- DONE:
  - done=1 for exactly one cycle, then wait in DONE with busy=1 until start=0, then go to IDLE.
  - frame_cnt holds its final value until the next run begins.
- Continuous mode (num_frames=0):
  - Never enters DONE.
  - frame_cnt wraps modulo 2^FRAME_CNT_W.
- Patterns, as a function of (x, y) using mode_q:
  - 0 counter: y*H_ACTIVE+x, modulo 2^DATA_WIDTH.
  - 1 bars: bar index = x*8/H_ACTIVE, giving white, yellow, cyan, green, magenta, red, blue, black. Components are all-ones or zero.
  - 2 ramp: R=G=B = x modulo 2^COMP_WIDTH.
  - 3 checker: ((x>>CHECK_LOG2)^(y>>CHECK_LOG2))&1 ? all-ones : zero.
- Pattern computation: the next pixel is computed from next x/y and registered. There are no combinational paths from vtready to vtdata.

Decomposition:
- Package sim_video_pkg:
  - mode encodings MODE_COUNTER/MODE_BARS/MODE_RAMP/MODE_CHECKER.
  - state enum.
  - the 8 bar colour constants, as functions of COMP_WIDTH.
- One sub-module: sim_video_pattern. It is combinational; inputs mode, x, y; output pixel. It contains all pattern arithmetic.
- The top module holds the FSM, counters and output registers.

Test Plan:
Bench parameters: H_ACTIVE=8, V_ACTIVE=4, LINE_GAP=2, FRAME_GAP=3, unless stated otherwise.
1. mode=0, num_frames=1, vtready=1 -> 32 beats carrying data 0..31, vtuser on beat 0 only, vtlast on beats 7/15/23/31. Exactly 2 idle cycles between lines. done pulses once; frame_cnt=1.
2. mode=1, vtready toggling 3-on/1-off plus random stalls -> data/last/user stable while stalled. Bar sequence 0xFFFFFF, 0xFFFF00, 0x00FFFF, 0x00FF00, 0xFF00FF, 0xFF0000, 0x0000FF, 0x000000 on every line. No lost or duplicated beats.
3. mode=3, CHECK_LOG2=1 -> line 0 = 00,00,FF,FF,00,00,FF,FF per component. Line 2 is inverted.
4. num_frames=0, start dropped mid-frame 2 -> frame 2 completes all 32 beats, then 3 idle cycles, IDLE, busy=0. No done pulse.
5. mode changed mid-frame from 0 to 2 -> current frame stays counter. The next frame is ramp: 0..7 per component.
6. rst asserted mid-line with vtvalid=1 -> outputs 0 in the same cycle. On restart, the first beat has vtuser=1 and data 0.
